// File: rtl/alu_fp8_if.sv
// Operand/result bundle for the FP8 E4M3 arithmetic unit.
// The master drives operands and opcode; the slave (the ALU) returns the result.
interface alu_fp8_if;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] opcode;
    logic [7:0] y;
    logic       is_output_valid;

    modport master (output a, b, opcode, input y, is_output_valid);
    modport slave  (input a, b, opcode, output y, is_output_valid);
endinterface

// File: rtl/alu_fp8.sv
// Multi-cycle FP8 (E4M3, bias 7) ADD/SUB/MUL unit: one operation per reset release,
// fixed 4-edge latency, truncating rounding, saturation on overflow, flush on underflow.
module alu_fp8 (
    input  logic      clock,
    input  logic      reset,
    alu_fp8_if.slave  bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] EXEC = 3'd2;
    localparam logic [2:0] NORM = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;

    logic [2:0] state;
    logic [3:0] op_r;
    logic       sa, sb;
    logic [3:0] ea, eb;
    logic [2:0] ma, mb;

    // Significand with binary point between bits 6 and 5; bit 7 set means >= 2.0.
    logic              ex_sign;
    logic signed [7:0] ex_exp;
    logic        [7:0] ex_sig;
    logic        [7:0] pack_r;
    logic        [7:0] y_r;
    logic              valid_r;

    logic              ex_sign_d;
    logic signed [7:0] ex_exp_d;
    logic        [7:0] ex_sig_d;
    logic              sx, sy;
    logic        [3:0] ex, ey, d;
    logic        [2:0] mx, my;
    logic        [6:0] x7, y7;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        ex_sign_d = 1'b0;
        ex_exp_d  = '0;
        ex_sig_d  = '0;
        sx = 1'b0; ex = '0; mx = '0;
        sy = 1'b0; ey = '0; my = '0;
        d  = '0;   x7 = '0; y7 = '0;
        if (op_r == OP_MUL) begin
            if (ea != 4'd0 && eb != 4'd0) begin
                ex_sign_d = sa ^ sb;
                ex_exp_d  = 8'(ea) + 8'(eb) - 8'd7;
                ex_sig_d  = 8'({1'b1, ma}) * 8'({1'b1, mb});
            end
        end else if (op_r == OP_ADD || op_r == OP_SUB) begin
            if (ea == 4'd0 && eb == 4'd0) begin
                ex_sig_d = '0;
            end else if (eb == 4'd0) begin
                ex_sign_d = sa;
                ex_exp_d  = 8'(ea);
                ex_sig_d  = {2'b01, ma, 3'b000};
            end else if (ea == 4'd0) begin
                ex_sign_d = sb;
                ex_exp_d  = 8'(eb);
                ex_sig_d  = {2'b01, mb, 3'b000};
            end else begin
                if ({ea, ma} >= {eb, mb}) begin
                    sx = sa; ex = ea; mx = ma;
                    sy = sb; ey = eb; my = mb;
                end else begin
                    sx = sb; ex = eb; mx = mb;
                    sy = sa; ey = ea; my = ma;
                end
                d  = ex - ey;
                x7 = {1'b1, mx, 3'b000};
                y7 = (d >= 4'd8) ? 7'd0 : ({1'b1, my, 3'b000} >> d);
                ex_sig_d  = (sx == sy) ? ({1'b0, x7} + {1'b0, y7})
                                       : ({1'b0, x7} - {1'b0, y7});
                ex_sign_d = sx;
                ex_exp_d  = 8'(ex);
            end
        end
    end

    logic        [2:0] lz;
    logic        [7:0] shifted;
    logic        [2:0] n_man;
    logic signed [7:0] n_exp;
    logic        [7:0] pack_d;

    always_comb begin
        lz = '0;
        for (int i = 0; i < 7; i++) begin
            if (ex_sig[i]) lz = 3'(6 - i);
        end
        shifted = ex_sig << lz;
        if (ex_sig[7]) begin
            n_man = ex_sig[6:4];
            n_exp = ex_exp + 8'sd1;
        end else begin
            n_man = shifted[5:3];
            n_exp = ex_exp - $signed({5'b00000, lz});
        end
        if (ex_sig == 8'd0 || n_exp <= 8'sd0)
            pack_d = 8'h00;
        else if (n_exp > 8'sd15)
            pack_d = {ex_sign, 7'h7F};
        else
            pack_d = {ex_sign, n_exp[3:0], n_man};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            op_r    <= '0;
            sa      <= 1'b0; ea <= '0; ma <= '0;
            sb      <= 1'b0; eb <= '0; mb <= '0;
            ex_sign <= 1'b0;
            ex_exp  <= '0;
            ex_sig  <= '0;
            pack_r  <= '0;
            y_r     <= '0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    op_r  <= bus.opcode;
                    sa    <= bus.a[7];
                    ea    <= bus.a[6:3];
                    ma    <= bus.a[2:0];
                    sb    <= bus.b[7] ^ (bus.opcode == OP_SUB);
                    eb    <= bus.b[6:3];
                    mb    <= bus.b[2:0];
                    state <= LOAD;
                end
                LOAD: begin
                    ex_sign <= ex_sign_d;
                    ex_exp  <= ex_exp_d;
                    ex_sig  <= ex_sig_d;
                    state   <= EXEC;
                end
                EXEC: begin
                    pack_r <= pack_d;
                    state  <= NORM;
                end
                NORM: begin
                    y_r     <= pack_r;
                    valid_r <= 1'b1;
                    state   <= DONE;
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.y               = y_r;
    assign bus.is_output_valid = valid_r;
endmodule

// File: tb/tb_alu_fp8.sv
// Scoreboard bench for alu_fp8: directed vectors push hand-computed results, and a
// negedge monitor pops and compares result and latency when valid rises.
module tb_alu_fp8;
    logic clock;
    logic reset;
    alu_fp8_if bus ();

    alu_fp8 dut (.clock(clock), .reset(reset), .bus(bus));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        string      name;
        logic [7:0] y;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: counts edges since reset release and scores each rising valid.
    initial begin
        int   cnt;
        logic prev;
        exp_t e;
        cnt  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                cnt  = 0;
                prev = 1'b0;
            end else begin
                cnt++;
                if (bus.is_output_valid && !prev) begin
                    if (q.size() == 0) begin
                        check("spurious_valid", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        check(e.name, int'(bus.y), int'(e.y));
                        check({e.name, "_latency"}, cnt, 4);
                    end
                end
                prev = bus.is_output_valid;
            end
        end
    end

    task automatic run_vec(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [7:0] y_exp);
        exp_t e;
        int   waited;
        @(negedge clock);
        #1;
        reset      = 1'b0;
        bus.a      = a;
        bus.b      = b;
        bus.opcode = op;
        @(negedge clock);
        check({name, "_rst_y"}, int'(bus.y), 0);
        check({name, "_rst_valid"}, int'(bus.is_output_valid), 0);
        e.name = name;
        e.y    = y_exp;
        q.push_back(e);
        #1;
        reset = 1'b1;
        @(negedge clock);
        #1;
        bus.a      = ~a;
        bus.b      = ~b;
        bus.opcode = ~op;
        waited = 0;
        while (q.size() != 0 && waited < 12) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (q.size() != 0) begin
            check({name, "_timeout"}, q.size(), 0);
            q.delete();
        end
        repeat (3) @(negedge clock);
        check({name, "_hold_y"}, int'(bus.y), int'(y_exp));
        check({name, "_hold_valid"}, int'(bus.is_output_valid), 1);
    endtask

    initial begin
        reset      = 1'b0;
        bus.a      = '0;
        bus.b      = '0;
        bus.opcode = '0;
        repeat (2) @(negedge clock);

        run_vec("add_2p2",      8'h40, 8'h40, 4'b0001, 8'h48);
        run_vec("add_mixmag",   8'h28, 8'h10, 4'b0001, 8'h29);
        run_vec("add_tiny",     8'h50, 8'h10, 4'b0001, 8'h50);
        run_vec("add_cancel",   8'h50, 8'hD0, 4'b0001, 8'h00);
        run_vec("add_mix1",     8'h41, 8'hC0, 4'b0001, 8'h28);
        run_vec("add_mix2",     8'h48, 8'hD0, 4'b0001, 8'hC8);
        run_vec("add_negneg",   8'hC8, 8'hD0, 4'b0001, 8'hD4);
        run_vec("mul_2x2",      8'h40, 8'h40, 4'b0010, 8'h48);
        run_vec("mul_1x1",      8'h38, 8'h38, 4'b0010, 8'h38);
        run_vec("mul_1xm1",     8'h38, 8'hB8, 4'b0010, 8'hB8);
        run_vec("mul_frac",     8'h40, 8'h39, 4'b0010, 8'h41);
        run_vec("mul_negneg",   8'hAC, 8'hC0, 4'b0010, 8'h34);
        run_vec("mul_zero",     8'h00, 8'h00, 4'b0010, 8'h00);
        run_vec("unsupported",  8'h40, 8'h40, 4'b1111, 8'h00);
        run_vec("mul_overflow", 8'h78, 8'h78, 4'b0010, 8'h7F);
        run_vec("sub_4m2",      8'h48, 8'h40, 4'b0011, 8'h40);

        // Abort: reset re-asserted while the operation sits in EXEC.
        @(negedge clock);
        #1;
        reset      = 1'b0;
        bus.a      = 8'h40;
        bus.b      = 8'h40;
        bus.opcode = 4'b0001;
        @(negedge clock);
        #1;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_y", int'(bus.y), 0);
        check("abort_valid", int'(bus.is_output_valid), 0);
        repeat (4) @(negedge clock);
        check("abort_still_idle", int'(bus.is_output_valid), 0);

        run_vec("after_abort",  8'h40, 8'h40, 4'b0001, 8'h48);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
